// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: shared constants for the MIPS run/step controller.
//   - FSM state encodings (ST_*), kept as plain 2-bit constants
//   - run mode encodings (MODE_*) as presented on the mode input
//   - stop cause encodings (CAUSE_*) as presented on done_cause
//   - DEFAULT_HALT_INSTR: encoding treated as the halt instruction
package cpu_run_pkg;

  typedef logic [1:0] run_state_t;

  localparam run_state_t ST_IDLE   = 2'd0;
  localparam run_state_t ST_RUN    = 2'd1;
  localparam run_state_t ST_STEP   = 2'd2;
  localparam run_state_t ST_HALTED = 2'd3;

  localparam logic [1:0] MODE_BUDGET = 2'b00;
  localparam logic [1:0] MODE_STEP   = 2'b01;
  localparam logic [1:0] MODE_BP     = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  localparam logic [1:0] CAUSE_BUDGET = 2'b00;
  localparam logic [1:0] CAUSE_HALT   = 2'b01;
  localparam logic [1:0] CAUSE_BP     = 2'b10;
  localparam logic [1:0] CAUSE_ABORT  = 2'b11;

  localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0000_000C;

endpackage

// File: rtl/cpu_pc_history.sv
// cpu_pc_history: ring buffer of the most recent executed PCs.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   clear          one-cycle clear (new run started)
//   wr_en          core executed an instruction this cycle
//   wr_pc          PC of that instruction
//   rd_idx         0 = newest entry, 1 = the one before, ...
//   rd_pc          combinational read data; never-written entries read 0
module cpu_pc_history
  import cpu_run_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
)(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [PC_W-1:0]  wr_pc,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [PC_W-1:0]  rd_pc
);

  logic [PC_W-1:0]  mem [DEPTH];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_pc;
      wr_ptr      <= wr_ptr + IDX_W'(1);
    end
  end

  // wr_ptr points at the next free slot; newest entry sits just behind it.
  assign rd_ptr = wr_ptr - IDX_W'(1) - rd_idx;
  assign rd_pc  = mem[rd_ptr];

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step controller producing the per-cycle enable of the
// single-cycle MIPS core (the core clock itself is never gated).
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   start          pulse: begin a run with mode/cycle_budget/bp_addr
//   step           pulse/level: one instruction per cycle in step mode
//   abort          pulse: stop any active run
//   mode           00 budget, 01 step, 10 breakpoint, 11 same as 00
//   cycle_budget   cycles to run in budget mode, 0 = unlimited
//   bp_addr        breakpoint PC for breakpoint mode
//   pc, instr      current core PC and the instruction at it
//   cpu_en         core advances on edges where this is 1
//   busy           high while running or stepping
//   done           one-cycle pulse on entry to HALTED
//   done_cause     00 budget, 01 halt, 10 breakpoint, 11 abort
//   cycle_count    instructions retired since the last start (saturating)
// Optional build macro CPU_PC_HISTORY_EN adds hist_idx/hist_pc, a
// combinational view into the last HIST_DEPTH executed PCs.
// Control protocol: start/step/abort are single-cycle strobes with no
// ready/ack; start is only accepted in IDLE or HALTED (dropped while busy),
// abort is only meaningful while busy, and step only in STEP.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int          CYCLE_W    = 16,
  parameter int          PC_W       = 32,
  parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
`ifdef CPU_PC_HISTORY_EN
  ,
  parameter int          HIST_DEPTH = 4,
  localparam int         HIST_IDX_W = $clog2(HIST_DEPTH)
`endif
)(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               step,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [CYCLE_W-1:0] cycle_budget,
  input  logic [PC_W-1:0]    bp_addr,
  input  logic [PC_W-1:0]    pc,
  input  logic [31:0]        instr,
  output logic               cpu_en,
  output logic               busy,
  output logic               done,
  output logic [1:0]         done_cause,
  output logic [CYCLE_W-1:0] cycle_count
`ifdef CPU_PC_HISTORY_EN
  ,
  input  logic [HIST_IDX_W-1:0] hist_idx,
  output logic [PC_W-1:0]       hist_pc
`endif
);

  run_state_t         state;
  logic [1:0]         mode_q;
  logic [CYCLE_W-1:0] budget_q;
  logic [PC_W-1:0]    bp_q;

  logic       is_halt, is_bp, is_budget;
  logic       accept_start;
  logic       stop;
  logic [1:0] stop_cause;
  logic       run_en;

  assign is_halt   = (instr == HALT_INSTR);
  assign is_bp     = (mode_q == MODE_BP) && (pc == bp_q);
  assign is_budget = (mode_q == MODE_BUDGET) && (budget_q != '0) &&
                     (cycle_count == budget_q);

  assign accept_start = start && ((state == ST_IDLE) || (state == ST_HALTED));

  // Stop checks look at the instruction about to execute, so a halt or
  // breakpoint instruction is never executed. Order encodes priority.
  always_comb begin
    stop       = 1'b0;
    stop_cause = CAUSE_BUDGET;
    run_en     = 1'b0;
    case (state)
      ST_RUN: begin
        if (abort) begin
          stop = 1'b1; stop_cause = CAUSE_ABORT;
        end else if (is_halt) begin
          stop = 1'b1; stop_cause = CAUSE_HALT;
        end else if (is_bp) begin
          stop = 1'b1; stop_cause = CAUSE_BP;
        end else if (is_budget) begin
          stop = 1'b1; stop_cause = CAUSE_BUDGET;
        end else begin
          run_en = 1'b1;
        end
      end
      ST_STEP: begin
        if (abort) begin
          stop = 1'b1; stop_cause = CAUSE_ABORT;
        end else if (step && is_halt) begin
          stop = 1'b1; stop_cause = CAUSE_HALT;
        end else begin
          run_en = step;
        end
      end
      default: ;
    endcase
  end

  // Reset gates the enable combinationally so the core does not advance on
  // the same edge that resets this controller.
  assign cpu_en = run_en && !reset;
  assign busy   = (state == ST_RUN) || (state == ST_STEP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      mode_q      <= MODE_BUDGET;
      budget_q    <= '0;
      bp_q        <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      done_cause  <= CAUSE_BUDGET;
    end else begin
      done <= 1'b0;
      if (accept_start) begin
        // Reserved mode behaves as budget mode; fold it at latch time.
        mode_q      <= (mode == MODE_RSVD) ? MODE_BUDGET : mode;
        budget_q    <= cycle_budget;
        bp_q        <= bp_addr;
        cycle_count <= '0;
        done_cause  <= CAUSE_BUDGET;
        state       <= (mode == MODE_STEP) ? ST_STEP : ST_RUN;
      end else if (stop) begin
        state      <= ST_HALTED;
        done       <= 1'b1;
        done_cause <= stop_cause;
      end else if (run_en && (cycle_count != '1)) begin
        cycle_count <= cycle_count + CYCLE_W'(1);
      end
    end
  end

`ifdef CPU_PC_HISTORY_EN
  cpu_pc_history #(
    .PC_W  (PC_W),
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept_start),
    .wr_en  (cpu_en),
    .wr_pc  (pc),
    .rd_idx (hist_idx),
    .rd_pc  (hist_pc)
  );
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: self-checking bench for cpu_run_ctrl. A tiny core model
// (PC advancing by 4 per enabled edge, one programmable halt location)
// feeds pc/instr; expected behaviour is derived per run from the earliest
// stop event and its priority.
module tb_cpu_run_ctrl;

  localparam int          CYCLE_W = 16;
  localparam int          PC_W    = 32;
  localparam logic [31:0] HALT    = 32'h0000_000C;
  localparam logic [31:0] NOP     = 32'h0000_0020;
  localparam logic [31:0] FAR_PC  = 32'hFFFF_FFF0;

  logic               clock;
  logic               reset;
  logic               start, step, abort;
  logic [1:0]         mode;
  logic [CYCLE_W-1:0] cycle_budget;
  logic [PC_W-1:0]    bp_addr;
  logic [PC_W-1:0]    pc;
  logic [31:0]        instr;
  logic               cpu_en, busy, done;
  logic [1:0]         done_cause;
  logic [CYCLE_W-1:0] cycle_count;
`ifdef CPU_PC_HISTORY_EN
  logic [1:0]         hist_idx;
  logic [PC_W-1:0]    hist_pc;
`endif

  cpu_run_ctrl #(
    .CYCLE_W (CYCLE_W),
    .PC_W    (PC_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .step         (step),
    .abort        (abort),
    .mode         (mode),
    .cycle_budget (cycle_budget),
    .bp_addr      (bp_addr),
    .pc           (pc),
    .instr        (instr),
    .cpu_en       (cpu_en),
    .busy         (busy),
    .done         (done),
    .done_cause   (done_cause),
    .cycle_count  (cycle_count)
`ifdef CPU_PC_HISTORY_EN
    ,
    .hist_idx     (hist_idx),
    .hist_pc      (hist_pc)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [17:0] exp_q[$];        // {cause, retired count} per expected done
  logic [31:0] hist_q[$];       // PCs executed since the last start
  logic [31:0] core_pc;
  logic [31:0] halt_pc;
  logic        seen_en;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle's inputs just after the falling edge, let them settle.
  task automatic apply(input logic s, input logic st, input logic ab);
    logic [17:0] e;
    pc    = core_pc;
    instr = (core_pc == halt_pc) ? HALT : NOP;
    start = s;
    step  = st;
    abort = ab;
    #1;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("done_unexpected", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_cause", 32'(done_cause), 32'(e[17:16]));
        check_eq("sb_count", 32'(cycle_count), 32'(e[15:0]));
      end
    end
  endtask

  // Let the rising edge happen; the modelled core moves on if enabled.
  task automatic advance();
    seen_en = cpu_en;
    if (seen_en) hist_q.push_back(pc);
    @(negedge clock);
    if (seen_en) core_pc = core_pc + 32'd4;
  endtask

  task automatic check_history();
`ifdef CPU_PC_HISTORY_EN
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      hist_idx = 2'(i);
      #1;
      e = (i < hist_q.size()) ? hist_q[hist_q.size() - 1 - i] : 32'd0;
      check_eq($sformatf("hist_%0d", i), hist_pc, e);
    end
`endif
  endtask

  // Free run (modes 00/10/11). Index arguments are instruction numbers,
  // -1 meaning "never". In a run every cycle before the stop retires one
  // instruction, so cycle k sees pc = 4k and cycle_count = k.
  task automatic run_scenario(input logic [1:0] md, input int bud,
                              input int bp_idx, input int halt_idx,
                              input int abort_at, input bit rnd_start);
    int   s_cyc;
    logic [1:0] cause;
    logic eff_bp;
    eff_bp       = (md == 2'b10);
    core_pc      = 0;
    halt_pc      = (halt_idx >= 0) ? 32'(halt_idx * 4) : FAR_PC;
    mode         = md;
    cycle_budget = 16'(bud);
    bp_addr      = (bp_idx >= 0) ? 32'(bp_idx * 4) : FAR_PC;
    s_cyc = 100000;
    if (abort_at >= 0 && abort_at < s_cyc) s_cyc = abort_at;
    if (halt_idx >= 0 && halt_idx < s_cyc) s_cyc = halt_idx;
    if (eff_bp && bp_idx >= 0 && bp_idx < s_cyc) s_cyc = bp_idx;
    if (!eff_bp && bud != 0 && bud < s_cyc) s_cyc = bud;
    if (abort_at == s_cyc)                     cause = 2'b11;
    else if (halt_idx == s_cyc)                cause = 2'b01;
    else if (eff_bp && bp_idx == s_cyc)        cause = 2'b10;
    else                                       cause = 2'b00;
    exp_q.push_back({cause, 16'(s_cyc)});

    apply(1'b1, 1'b0, 1'b0);
    check_eq("start_en", 32'(cpu_en), 32'd0);
    hist_q.delete();
    advance();
    for (int k = 0; k <= s_cyc; k++) begin
      apply(rnd_start && ($urandom_range(0, 2) == 0), 1'b0, k == abort_at);
      check_eq("run_en", 32'(cpu_en), 32'(k < s_cyc));
      check_eq("run_busy", 32'(busy), 32'd1);
      check_eq("run_count", 32'(cycle_count), 32'(k));
      check_eq("run_done", 32'(done), 32'd0);
      advance();
    end
    apply(1'b0, 1'b0, 1'b0);
    check_eq("halt_done", 32'(done), 32'd1);
    check_eq("halt_busy", 32'(busy), 32'd0);
    check_eq("halt_cause", 32'(done_cause), 32'(cause));
    check_eq("halt_count", 32'(cycle_count), 32'(s_cyc));
    advance();
    apply(1'b0, 1'b0, 1'b1);  // abort while halted has no effect
    check_eq("hold_done", 32'(done), 32'd0);
    check_eq("hold_en", 32'(cpu_en), 32'd0);
    check_eq("hold_cause", 32'(done_cause), 32'(cause));
    check_history();
    advance();
  endtask

  // Step mode: step_pat/start_pat give per-cycle strobes; the run ends at
  // abort_at (forced on the last cycle) or on a step onto the halt.
  task automatic step_scenario(input logic [31:0] step_pat,
                               input logic [31:0] start_pat,
                               input int halt_idx, input int abort_at);
    int  retired;
    bit  stopped;
    bit  ab, st;
    logic [1:0] cause;
    core_pc      = 0;
    halt_pc      = (halt_idx >= 0) ? 32'(halt_idx * 4) : FAR_PC;
    mode         = 2'b01;
    cycle_budget = 16'($urandom_range(1, 3));  // ignored while stepping
    bp_addr      = 32'd0;                     // ignored while stepping
    apply(1'b1, 1'b0, 1'b0);
    check_eq("step_start_en", 32'(cpu_en), 32'd0);
    hist_q.delete();
    advance();
    retired = 0;
    stopped = 0;
    cause   = 2'b00;
    for (int k = 0; k < 32 && !stopped; k++) begin
      st = step_pat[k];
      ab = (k == abort_at) || (k == 31);
      apply(start_pat[k], st, ab);
      check_eq("step_en", 32'(cpu_en), 32'(st && !ab && retired != halt_idx));
      check_eq("step_busy", 32'(busy), 32'd1);
      check_eq("step_count", 32'(cycle_count), 32'(retired));
      if (ab) begin
        stopped = 1; cause = 2'b11;
      end else if (st && retired == halt_idx) begin
        stopped = 1; cause = 2'b01;
      end else if (st) begin
        retired++;
      end
      if (stopped) exp_q.push_back({cause, 16'(retired)});
      advance();
    end
    apply(1'b0, 1'b0, 1'b0);
    check_eq("step_done", 32'(done), 32'd1);
    check_eq("step_halt_cause", 32'(done_cause), 32'(cause));
    check_eq("step_final_count", 32'(cycle_count), 32'(retired));
    advance();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    start = 0; step = 0; abort = 0;
    mode = 0; cycle_budget = 0; bp_addr = 0;
    core_pc = 0; halt_pc = FAR_PC;
    pc = 0; instr = NOP;
`ifdef CPU_PC_HISTORY_EN
    hist_idx = 0;
`endif
    @(negedge clock);
    apply(1'b0, 1'b0, 1'b0);
    advance();
    apply(1'b0, 1'b0, 1'b0);
    check_eq("rst_en", 32'(cpu_en), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_cause", 32'(done_cause), 32'd0);
    check_eq("rst_count", 32'(cycle_count), 32'd0);
    advance();
    reset = 1'b0;

    // Directed cases
    run_scenario(2'b00, 10, -1, -1, -1, 0);  // budget 10
    run_scenario(2'b10, 0, 3, -1, -1, 0);    // breakpoint at 0x0C
    run_scenario(2'b00, 0, -1, 5, -1, 0);    // halt at 0x14, unlimited
    run_scenario(2'b10, 0, 3, -1, 3, 0);     // abort beats breakpoint
    run_scenario(2'b10, 0, 0, -1, -1, 0);    // breakpoint at start pc
    run_scenario(2'b11, 4, 2, -1, -1, 0);    // reserved mode, bp ignored
    run_scenario(2'b10, 0, 4, 4, -1, 0);     // halt beats breakpoint
    run_scenario(2'b00, 3, -1, 3, -1, 0);    // halt beats budget
    run_scenario(2'b00, 6, -1, -1, -1, 0);   // six PCs for history
    run_scenario(2'b00, 2, -1, -1, -1, 0);   // history partly unwritten
    run_scenario(2'b00, 7, -1, -1, -1, 1);   // starts while busy ignored
    step_scenario(32'b0000_0001_0010_0100, 32'b0000_0000_1000_1010, -1, 10);
    step_scenario(32'h0000_FFFF, 32'd0, 2, -1);  // step held onto halt

    // Reset in the middle of a run
    core_pc = 0; halt_pc = FAR_PC; mode = 2'b00; cycle_budget = 0;
    apply(1'b1, 1'b0, 1'b0);
    advance();
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 1'b0, 1'b0);
      check_eq("pre_rst_en", 32'(cpu_en), 32'd1);
      advance();
    end
    reset = 1'b1;
    apply(1'b0, 1'b0, 1'b0);
    check_eq("mid_rst_en", 32'(cpu_en), 32'd0);
    advance();
    reset = 1'b0;
    apply(1'b0, 1'b0, 1'b0);
    check_eq("post_rst_en", 32'(cpu_en), 32'd0);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    check_eq("post_rst_count", 32'(cycle_count), 32'd0);
    check_eq("post_rst_cause", 32'(done_cause), 32'd0);
    advance();

    // Randomized runs
    for (int n = 0; n < 60; n++) begin
      logic [1:0] md;
      int bud, bpi, hi, ai;
      md = 2'($urandom_range(0, 3));
      if (md == 2'b01) begin
        hi = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 8));
        ai = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 30));
        step_scenario($urandom, $urandom & $urandom, hi, ai);
      end else begin
        bud = int'($urandom_range(0, 20));
        bpi = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 25));
        hi  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 25));
        ai  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
        if (md != 2'b10 && bud == 0 && hi < 0 && ai < 0) ai = 30;
        if (md == 2'b10 && bpi < 0 && hi < 0 && ai < 0) ai = 30;
        run_scenario(md, bud, bpi, hi, ai, $urandom_range(0, 1) == 1);
      end
    end

    // ---------------- final report ----------------
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesizable run/step controller that gates the single-cycle MIPS core through a per-cycle enable, replacing fixed hand-toggled clock sequences with programmable execution.
Supports budgeted free-run, single-step and run-to-breakpoint modes, plus halt-instruction detection and a retired-cycle counter.
Sits between the bench or debug front-end and the `mips` core's enable input; the core clock itself is never gated.

Parameters:
CYCLE_W, 16, width of cycle budget and cycle counter
PC_W, 32, program-counter width
HALT_INSTR, 32'h0000000C, instruction encoding treated as halt
HIST_DEPTH, 4, PC history entries (optional feature only; power of two)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a run using mode/budget/bp_addr sampled that cycle
step  in  1  one-cycle pulse; advances exactly one instruction in STEP mode
abort  in  1  one-cycle pulse; stops any run
mode  in  2  00 budget run, 01 single-step, 10 run-to-breakpoint, 11 reserved (treated as 00)
cycle_budget  in  CYCLE_W  cycles to execute in mode 00; 0 means no limit
bp_addr  in  PC_W  breakpoint PC for mode 10
pc  in  PC_W  current core PC
instr  in  32  instruction at pc
cpu_en  out  1  core advances on clock edges where this is 1
busy  out  1  high in RUN or STEP
done  out  1  one-cycle pulse on entry to HALTED
done_cause  out  2  00 budget, 01 halt instr, 10 breakpoint, 11 abort; held until next start
cycle_count  out  CYCLE_W  instructions retired since last start; saturates at all-ones

Behaviour:
- Reset: state IDLE; all outputs 0; latched mode, budget and bp cleared. Reset mid-run drops cpu_en in the same cycle the reset edge is taken.
- States: IDLE, RUN, STEP, HALTED.
- IDLE or HALTED + start: latch inputs and clear cycle_count. Next state RUN for modes 00/10/11, STEP for mode 01. start while busy is ignored.
- RUN: cpu_en=1 combinationally unless a stop condition is true that cycle. Each clock edge with cpu_en=1 increments cycle_count.
- Stop conditions, checked on the current pc/instr before enabling:
  - abort
  - instr==HALT_INSTR
  - mode 10 and pc==bp_addr
  - mode 00 and budget!=0 and cycle_count==budget
- Stop priority when several hold in the same cycle: abort > halt > breakpoint > budget.
- On stop: cpu_en=0 that cycle, go to HALTED, pulse done next cycle, latch done_cause. The halt instruction and the breakpoint instruction are not executed.
- Breakpoint at the start PC halts immediately with cycle_count=0.
- STEP: cpu_en=1 only in a cycle where step=1 and no halt/abort condition holds. Each such cycle increments cycle_count.
  - halt instruction with step=1 → HALTED, cause 01
  - abort → HALTED, cause 11
  - step held high advances one instruction per cycle
- HALTED: cpu_en=0; outputs hold until the next start. Abort in IDLE or HALTED is ignored.
- Latency: start → first cpu_en=1 is 1 cycle. Stop condition → cpu_en low is 0 cycles. Stop → done is 1 cycle.

Optional Feature:
CPU_PC_HISTORY_EN
- Defined: adds ports hist_idx in $clog2(HIST_DEPTH) and hist_pc out PC_W.
  - Each enabled cycle writes pc into a ring buffer of HIST_DEPTH entries; the write pointer wraps.
  - hist_idx=0 returns the most recent PC, 1 the one before, and so on; read is combinational.
  - Entries not yet written read 0. Buffer clears on reset and on start.
- Undefined: ports absent, no storage.

Decomposition:
- Package cpu_run_pkg: state enum, mode encodings, done_cause encodings, default HALT_INSTR constant.
- One sub-module: cpu_pc_history (ring buffer), instantiated only under CPU_PC_HISTORY_EN.

Test Plan:
- Mode 00, budget=10, straight-line program: cpu_en high for exactly 10 cycles; done pulse one cycle later; done_cause=00; cycle_count=10.
- Mode 10, bp_addr=0x0000000C, sequential PCs from 0: 3 enabled cycles; halts with pc=0x0C unexecuted; cause 10; cycle_count=3.
- HALT_INSTR at PC 0x14 with budget 0: 5 enabled cycles; cause 01.
- Abort and breakpoint true in the same cycle: cause 11; cpu_en=0 that cycle.
- Mode 01: three step pulses separated by idle cycles give exactly 3 enabled cycles and cycle_count=3; start pulses while busy are ignored.
- Reset asserted mid-run at cycle 4: cpu_en=0 and busy=0 from the next edge; cycle_count=0.
- With CPU_PC_HISTORY_EN, after 6 sequential PCs (0x00–0x14): hist_idx 0..3 read 0x14, 0x10, 0x0C, 0x08.
